// File: rtl/systolic_feeder.sv
// Operand sequencer for the 2x2 output-stationary systolic array.
// Define FEEDER_DBUF_EN for ping-pong tile buffers that load during streaming.
module systolic_feeder #(
    parameter int DATA_WIDTH   = 17,
    parameter int K_DEPTH      = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_a,
    input  logic [2*DATA_WIDTH-1:0] in_b,
    output logic [DATA_WIDTH-1:0]   data_a_0_o,
    output logic [DATA_WIDTH-1:0]   data_a_1_o,
    output logic [DATA_WIDTH-1:0]   data_b_0_o,
    output logic [DATA_WIDTH-1:0]   data_b_1_o,
    output logic                    acc_clr_o,
    output logic                    acc_en_o,
    output logic                    done_o
);

`ifdef FEEDER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    localparam int NB   = DBUF ? 2 : 1;
    localparam int W2   = 2 * DATA_WIDTH;
    localparam int MW   = $clog2(NB * K_DEPTH);
    localparam int CW   = $clog2(K_DEPTH);
    localparam int MAXC = (K_DEPTH > DRAIN_CYCLES) ? K_DEPTH : DRAIN_CYCLES;
    localparam int SW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] C_LAST = CW'(K_DEPTH - 1);
    localparam logic [SW-1:0] S_K    = SW'(K_DEPTH);
    localparam logic [SW-1:0] D_LAST = SW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        LOAD,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   s_q, s_d;
    logic            full_q, full_d;
    logic            bank_q, bank_d;
    logic            ready_q, ready_d;
    logic            clr_q, clr_d;
    logic            en_q, en_d;
    logic            done_q, done_d;
    logic [DATA_WIDTH-1:0] a0_q, a0_d, a1_q, a1_d;
    logic [DATA_WIDTH-1:0] b0_q, b0_d, b1_q, b1_d;

    logic [W2-1:0] mem_a_q [NB*K_DEPTH];
    logic [W2-1:0] mem_b_q [NB*K_DEPTH];

    logic          accept;
    logic          last_beat;
    logic          rd_bank;
    logic [MW-1:0] wa, ra0, ra1;

    assign accept    = in_valid && ready_q;
    assign last_beat = accept && (cnt_q == C_LAST);
    assign wa        = MW'((bank_q ? K_DEPTH : 0) + int'(cnt_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        full_d  = full_q;
        bank_d  = bank_q;
        if (accept) begin
            cnt_d = last_beat ? '0 : cnt_q + CW'(1);
        end
        // A bank filled while another is in flight waits for DONE.
        if (DBUF && last_beat && state_q != LOAD) begin
            full_d = 1'b1;
        end
        unique case (state_q)
            LOAD: begin
                if (last_beat) begin
                    state_d = CLEAR;
                    bank_d  = DBUF ? ~bank_q : bank_q;
                end
            end
            CLEAR: begin
                state_d = STREAM;
                s_d     = '0;
            end
            STREAM: begin
                if (s_q == S_K) begin
                    s_d     = '0;
                    state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                end else begin
                    s_d = s_q + SW'(1);
                end
            end
            DRAIN: begin
                if (s_q == D_LAST) begin
                    s_d     = '0;
                    state_d = DONE;
                end else begin
                    s_d = s_q + SW'(1);
                end
            end
            DONE: begin
                if (DBUF && (full_q || last_beat)) begin
                    state_d = CLEAR;
                    bank_d  = ~bank_q;
                    full_d  = 1'b0;
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign rd_bank = DBUF ? ~bank_d : 1'b0;
    assign ra0 = MW'((rd_bank ? K_DEPTH : 0) + int'(s_d));
    assign ra1 = MW'((rd_bank ? K_DEPTH : 0) + int'(s_d) - 1);

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        ready_d = (state_d == LOAD) || (DBUF && !full_d);
        clr_d   = (state_d == CLEAR);
        en_d    = (state_d == STREAM) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
        a0_d    = '0;
        a1_d    = '0;
        b0_d    = '0;
        b1_d    = '0;
        if (state_d == STREAM) begin
            if (s_d < S_K) begin
                a0_d = mem_a_q[ra0][DATA_WIDTH-1:0];
                b0_d = mem_b_q[ra0][DATA_WIDTH-1:0];
            end
            if (s_d != '0) begin
                a1_d = mem_a_q[ra1][W2-1:DATA_WIDTH];
                b1_d = mem_b_q[ra1][W2-1:DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            s_q     <= '0;
            full_q  <= 1'b0;
            bank_q  <= 1'b0;
            ready_q <= 1'b1;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            a0_q    <= '0;
            a1_q    <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            full_q  <= full_d;
            bank_q  <= bank_d;
            ready_q <= ready_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            done_q  <= done_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem_a_q[wa] <= in_a;
            mem_b_q[wa] <= in_b;
        end
    end

    assign in_ready   = ready_q;
    assign acc_clr_o  = clr_q;
    assign acc_en_o   = en_q;
    assign done_o     = done_q;
    assign data_a_0_o = a0_q;
    assign data_a_1_o = a1_q;
    assign data_b_0_o = b0_q;
    assign data_b_1_o = b1_q;

endmodule
